// File: rtl/uart_tx_fifo_if.sv
// Write/status bundle of the buffered UART transmitter: the producer drives the
// write strobe and data, the transmitter reports FIFO and line status.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic                 uart_wr_i;
  logic [DATA_BITS-1:0] uart_dat_i;
  logic                 uart_full_o;
  logic [LVL_W-1:0]     uart_level_o;
  logic                 uart_busy_o;
  logic                 uart_ovf_o;

  modport master (
    output uart_wr_i, uart_dat_i,
    input  uart_full_o, uart_level_o, uart_busy_o, uart_ovf_o
  );

  modport slave (
    input  uart_wr_i, uart_dat_i,
    output uart_full_o, uart_level_o, uart_busy_o, uart_ovf_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of DATA_BITS-wide entries drained into
// start/data/parity/stop frames on uart_tx at CLK_HZ/BAUD clocks per bit.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           sys_clk_i,
  input  logic           sys_rstn_i,
  uart_tx_fifo_if.slave  bus,
  output logic           uart_tx
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level, level_nxt;
  logic                 full, ovf;
  logic                 push, pop;

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 tx_q;
  logic                 bit_tick, stop_done;

  assign bit_tick  = (baud_cnt == '0);
  assign stop_done = (state == STOP) && bit_tick && (bit_idx == STOP_LAST);
  assign push      = bus.uart_wr_i && !full;
  // A frame is loaded from IDLE, or straight out of the last stop-bit clock.
  assign pop       = (level != '0) && ((state == IDLE) || stop_done);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
      if (bus.uart_wr_i && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= bus.uart_dat_i;
  end

  always_ff @(posedge sys_clk_i) begin
    if (pop) begin
      shift   <= mem[rd_ptr];
      par_bit <= parity_of(mem[rd_ptr]);
    end else if (state == DATA && bit_tick) begin
      shift   <= shift >> 1;
    end
  end

  // Every state entry reloads the baud counter, so bit edges never drift.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            baud_cnt <= DIV_M1;
            bit_idx  <= '0;
            tx_q     <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state    <= DATA;
            baud_cnt <= DIV_M1;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            baud_cnt <= DIV_M1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                tx_q  <= par_bit;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        PAR: begin
          if (bit_tick) begin
            state    <= STOP;
            baud_cnt <= DIV_M1;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            baud_cnt <= DIV_M1;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (pop) begin
                state <= START;
                tx_q  <= 1'b0;
              end else begin
                state <= IDLE;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx          = tx_q;
  assign bus.uart_full_o  = full;
  assign bus.uart_level_o = level;
  assign bus.uart_ovf_o   = ovf;
  assign bus.uart_busy_o  = (state != IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 depth-4, 7E2 and 7O2 instances at 4 clocks/bit,
// with the line sampled every cycle into a log and compared against hand-derived frames.
module tb_uart_tx_fifo;
  localparam int DIV  = 4;
  localparam int LOGN = 1024;

  logic clk, rst_n;
  logic tx8, txe, txo;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [2:0] txlog [LOGN];

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b8 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) be ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bo ();

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(8), .FIFO_DEPTH(4),
                 .PARITY(0), .STOP_BITS(1))
    u8 (.sys_clk_i(clk), .sys_rstn_i(rst_n), .bus(b8.slave), .uart_tx(tx8));
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .FIFO_DEPTH(4),
                 .PARITY(2), .STOP_BITS(2))
    ue (.sys_clk_i(clk), .sys_rstn_i(rst_n), .bus(be.slave), .uart_tx(txe));
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .FIFO_DEPTH(4),
                 .PARITY(1), .STOP_BITS(2))
    uo (.sys_clk_i(clk), .sys_rstn_i(rst_n), .bus(bo.slave), .uart_tx(txo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc counts rising edges; the log slot for edge n holds the line after that edge.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) txlog[cyc % LOGN] <= {txo, txe, tx8};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Expected line level at offset j of a frame: start, data LSB first, optional parity, stop.
  function automatic logic exp_line(input logic [8:0] d, input int nb, input int pbit, input int j);
    int c;
    c = j / DIV;
    if (c == 0) return 1'b0;
    if (c <= nb) return d[c-1];
    if (c == nb + 1 && pbit >= 0) return pbit[0];
    return 1'b1;
  endfunction

  task automatic wait_until(input int target);
    if (target > cyc) repeat (target - cyc) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx8, txe, txo} !== 3'b111) begin
      errors++; $display("FAIL rst_tx got %b exp 111", {tx8, txe, txo});
    end
    checks++;
    if ({b8.uart_level_o, b8.uart_full_o, b8.uart_busy_o, b8.uart_ovf_o} !== 6'b000_000) begin
      errors++; $display("FAIL rst_status got %b exp 000000",
                         {b8.uart_level_o, b8.uart_full_o, b8.uart_busy_o, b8.uart_ovf_o});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx8, b8.uart_level_o, b8.uart_full_o, b8.uart_busy_o, b8.uart_ovf_o} !== 7'b1_000_000) begin
        errors++; $display("FAIL idle_c%0d got %b exp 1000000", i,
                           {tx8, b8.uart_level_o, b8.uart_full_o, b8.uart_busy_o, b8.uart_ovf_o});
      end
    end
  endtask

  task automatic test_single_frame;
    int k;
    b8.uart_wr_i = 1'b1; b8.uart_dat_i = 8'h55;
    @(posedge clk); #1;
    k = cyc;
    b8.uart_wr_i = 1'b0;
    checks++;
    if (b8.uart_level_o !== 3'd1) begin
      errors++; $display("FAIL single_level got %0d exp 1", b8.uart_level_o);
    end
    checks++;
    if (tx8 !== 1'b1) begin
      errors++; $display("FAIL single_tx_at_k got %b exp 1", tx8);
    end
    wait_until(k + 40);
    checks++;
    if (b8.uart_busy_o !== 1'b1) begin
      errors++; $display("FAIL single_busy_k40 got %b exp 1", b8.uart_busy_o);
    end
    wait_until(k + 41);
    checks++;
    if ({b8.uart_busy_o, b8.uart_level_o} !== 4'b0_000) begin
      errors++; $display("FAIL single_busy_k41 got %b exp 0000", {b8.uart_busy_o, b8.uart_level_o});
    end
    wait_until(k + 43);
    for (int j = 0; j < 42; j++) begin
      checks++;
      if (txlog[(k + 1 + j) % LOGN][0] !== ((j < 40) ? exp_line(9'h055, 8, -1, j) : 1'b1)) begin
        errors++; $display("FAIL single_tx_c%0d got %b exp %b", j, txlog[(k + 1 + j) % LOGN][0],
                           (j < 40) ? exp_line(9'h055, 8, -1, j) : 1'b1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d [5];
    int k;
    d = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    k = 0;
    b8.uart_wr_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b8.uart_dat_i = d[i];
      @(posedge clk); #1;
      if (i == 0) k = cyc;
    end
    b8.uart_wr_i = 1'b0;
    checks++;
    if ({b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o} !== 5'b100_1_0) begin
      errors++; $display("FAIL b2b_fill got %b exp 10010",
                         {b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o});
    end
    wait_until(k + 203);
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 40; j++) begin
        checks++;
        if (txlog[(k + 1 + 40 * n + j) % LOGN][0] !== exp_line({1'b0, d[n]}, 8, -1, j)) begin
          errors++; $display("FAIL b2b_f%0d_c%0d got %b exp %b", n, j,
                             txlog[(k + 1 + 40 * n + j) % LOGN][0], exp_line({1'b0, d[n]}, 8, -1, j));
        end
      end
    end
    checks++;
    if ({txlog[(k + 201) % LOGN][0], b8.uart_busy_o, b8.uart_level_o, b8.uart_ovf_o} !== 6'b1_0_000_0) begin
      errors++; $display("FAIL b2b_end got %b exp 100000",
                         {txlog[(k + 201) % LOGN][0], b8.uart_busy_o, b8.uart_level_o, b8.uart_ovf_o});
    end
  endtask

  task automatic test_overflow;
    int k;
    b8.uart_wr_i = 1'b1; b8.uart_dat_i = 8'h11;
    @(posedge clk); #1;
    k = cyc;
    b8.uart_wr_i = 1'b0;
    wait_until(k + 5);
    b8.uart_wr_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      b8.uart_dat_i = 8'(i);
      @(posedge clk); #1;
      if (i == 4) begin
        checks++;
        if ({b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o} !== 5'b100_1_0) begin
          errors++; $display("FAIL ovf_at4 got %b exp 10010",
                             {b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o});
        end
      end
    end
    b8.uart_wr_i = 1'b0;
    checks++;
    if ({b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o} !== 5'b100_1_1) begin
      errors++; $display("FAIL ovf_at5 got %b exp 10011",
                         {b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o});
    end
    wait_until(k + 212);
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 40; j++) begin
        checks++;
        if (txlog[(k + 1 + 40 * n + j) % LOGN][0] !== exp_line((n == 0) ? 9'h011 : 9'(n), 8, -1, j)) begin
          errors++; $display("FAIL ovf_f%0d_c%0d got %b exp %b", n, j,
                             txlog[(k + 1 + 40 * n + j) % LOGN][0],
                             exp_line((n == 0) ? 9'h011 : 9'(n), 8, -1, j));
        end
      end
    end
    for (int j = 201; j < 211; j++) begin
      checks++;
      if (txlog[(k + j) % LOGN][0] !== 1'b1) begin
        errors++; $display("FAIL ovf_idle_c%0d got %b exp 1", j, txlog[(k + j) % LOGN][0]);
      end
    end
    checks++;
    if ({b8.uart_busy_o, b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o} !== 6'b0_000_0_1) begin
      errors++; $display("FAIL ovf_sticky got %b exp 000001",
                         {b8.uart_busy_o, b8.uart_level_o, b8.uart_full_o, b8.uart_ovf_o});
    end
  endtask

  task automatic test_parity_stop;
    int k;
    be.uart_wr_i = 1'b1; be.uart_dat_i = 7'h03;
    bo.uart_wr_i = 1'b1; bo.uart_dat_i = 7'h03;
    @(posedge clk); #1;
    k = cyc;
    be.uart_wr_i = 1'b0; bo.uart_wr_i = 1'b0;
    wait_until(k + 44);
    checks++;
    if ({be.uart_busy_o, bo.uart_busy_o} !== 2'b11) begin
      errors++; $display("FAIL par_busy_k44 got %b exp 11", {be.uart_busy_o, bo.uart_busy_o});
    end
    wait_until(k + 45);
    checks++;
    if ({be.uart_busy_o, bo.uart_busy_o} !== 2'b00) begin
      errors++; $display("FAIL par_busy_k45 got %b exp 00", {be.uart_busy_o, bo.uart_busy_o});
    end
    wait_until(k + 47);
    for (int j = 0; j < 45; j++) begin
      checks++;
      if (txlog[(k + 1 + j) % LOGN][1] !== exp_line(9'h003, 7, 0, j)) begin
        errors++; $display("FAIL even_c%0d got %b exp %b", j, txlog[(k + 1 + j) % LOGN][1],
                           exp_line(9'h003, 7, 0, j));
      end
      checks++;
      if (txlog[(k + 1 + j) % LOGN][2] !== exp_line(9'h003, 7, 1, j)) begin
        errors++; $display("FAIL odd_c%0d got %b exp %b", j, txlog[(k + 1 + j) % LOGN][2],
                           exp_line(9'h003, 7, 1, j));
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d [3];
    int k;
    d = '{8'hF0, 8'h0F, 8'hAA};
    k = 0;
    b8.uart_wr_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b8.uart_dat_i = d[i];
      @(posedge clk); #1;
      if (i == 0) k = cyc;
    end
    b8.uart_wr_i = 1'b0;
    wait_until(k + 10);
    checks++;
    if ({tx8, b8.uart_level_o} !== 4'b0_010) begin
      errors++; $display("FAIL mid_before got %b exp 0010", {tx8, b8.uart_level_o});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx8, b8.uart_level_o, b8.uart_busy_o, b8.uart_full_o, b8.uart_ovf_o} !== 7'b1_000_000) begin
      errors++; $display("FAIL mid_async got %b exp 1000000",
                         {tx8, b8.uart_level_o, b8.uart_busy_o, b8.uart_full_o, b8.uart_ovf_o});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx8, b8.uart_level_o, b8.uart_busy_o} !== 5'b1_000_0) begin
        errors++; $display("FAIL post_rst_c%0d got %b exp 10000", i,
                           {tx8, b8.uart_level_o, b8.uart_busy_o});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b8.uart_wr_i = 1'b0; b8.uart_dat_i = '0;
    be.uart_wr_i = 1'b0; be.uart_dat_i = '0;
    bo.uart_wr_i = 1'b0; bo.uart_dat_i = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_parity_stop();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
